// File: rtl/pcl_3w_slave_pkg.sv
// Shared types and defaults for the PCL 3-wire bus responder.
package pcl_3w_slave_pkg;

    localparam int unsigned DefSyncStages = 2;
    localparam int unsigned DefAddrW      = 7;
    localparam int unsigned DefDataW      = 8;

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StCmd,
        StWdata,
        StRfetch,
        StRdata,
        StDone
    } state_e;

    // Command byte is {rnw, addr}; rnw sits directly above the address field.
    function automatic int unsigned cmd_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcl_3w_slave_sync.sv
// Multi-flop synchronizer for one asynchronous bus line with registered edge pulses.
module pcl_3w_slave_sync #(
    parameter int unsigned SyncStages = 2,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;
    logic                  rise_q;
    logic                  fall_q;

    // Level is taken from the edge flop so it lines up with the rise/fall pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SyncStages{ResetVal}};
            prev_q <= ResetVal;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d_i};
            prev_q <= sync_q[SyncStages-1];
            rise_q <= sync_q[SyncStages-1] & ~prev_q;
            fall_q <= ~sync_q[SyncStages-1] & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pcl_3w_slave.sv
// PCL 3-wire bus responder: decodes one command/data frame per chip-select onto a register port.
module pcl_3w_slave
    import pcl_3w_slave_pkg::*;
#(
    parameter int unsigned SyncStages = DefSyncStages,
    parameter int unsigned AddrW      = DefAddrW,
    parameter int unsigned DataW      = DefDataW
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_tw_clock,
    input  logic             in_tw_cs,
    inout  wire              io_tw_data,
    output logic [AddrW-1:0] out_reg_addr,
    output logic [DataW-1:0] out_reg_wdata,
    output logic             out_reg_wr,
    output logic             out_reg_rd,
    input  logic [DataW-1:0] in_reg_rdata,
    output logic             out_busy,
    output logic             out_frame_err
);

    localparam int unsigned     CmdW      = cmd_width(AddrW);
    localparam int unsigned     CmdRnwBit = AddrW;
    localparam int unsigned     ShW       = max_w(CmdW, DataW);
    localparam int unsigned     CntW      = $clog2(ShW);
    localparam logic [CntW-1:0] CmdLast   = CntW'(CmdW - 1);
    localparam logic [CntW-1:0] DataLast  = CntW'(DataW - 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic dat_lvl, dat_rise, dat_fall;
    logic unused_edges;

    pcl_3w_slave_sync #(
        .SyncStages (SyncStages),
        .ResetVal   (1'b0)
    ) u_sync_clk (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .d_i     (in_tw_clock),
        .level_o (clk_lvl),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    // cs resets high so a frame still in flight after reset is never mistaken for a new one.
    pcl_3w_slave_sync #(
        .SyncStages (SyncStages),
        .ResetVal   (1'b1)
    ) u_sync_cs (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .d_i     (in_tw_cs),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    pcl_3w_slave_sync #(
        .SyncStages (SyncStages),
        .ResetVal   (1'b0)
    ) u_sync_dat (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .d_i     (io_tw_data),
        .level_o (dat_lvl),
        .rise_o  (dat_rise),
        .fall_o  (dat_fall)
    );

    assign unused_edges = ^{clk_lvl, cs_fall, dat_rise, dat_fall};

    state_e           state_q;
    logic [CntW-1:0]  bit_cnt_q;
    logic [ShW-1:0]   shift_in_q;
    logic [ShW-1:0]   shift_in_nxt;
    logic [DataW-1:0] shift_out_q;
    logic [AddrW-1:0] addr_q;
    logic [DataW-1:0] wdata_q;
    logic             wr_q;
    logic             rd_q;
    logic             busy_q;
    logic             err_q;
    logic             oe_q;
    logic             dout_q;
    logic             last_q;
    logic             in_frame;

    assign shift_in_nxt = {shift_in_q[ShW-2:0], dat_lvl};
    assign in_frame     = state_q inside {StCmd, StWdata, StRfetch, StRdata};

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q     <= StWaitIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            err_q <= 1'b0;
            // A dropped cs overrides any bus edge seen in the same cycle.
            if (in_frame && !cs_lvl) begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                oe_q      <= 1'b0;
                err_q     <= 1'b1;
                last_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StWaitIdle: begin
                        if (!cs_lvl) begin
                            state_q <= StIdle;
                        end
                    end
                    StIdle: begin
                        if (cs_rise) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                    StCmd: begin
                        if (clk_rise) begin
                            shift_in_q <= shift_in_nxt;
                            if (bit_cnt_q == CmdLast) begin
                                bit_cnt_q <= '0;
                                addr_q    <= shift_in_nxt[AddrW-1:0];
                                if (shift_in_nxt[CmdRnwBit]) begin
                                    rd_q    <= 1'b1;
                                    state_q <= StRfetch;
                                end else begin
                                    state_q <= StWdata;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StWdata: begin
                        if (clk_rise) begin
                            shift_in_q <= shift_in_nxt;
                            if (bit_cnt_q == DataLast) begin
                                bit_cnt_q <= '0;
                                wdata_q   <= shift_in_nxt[DataW-1:0];
                                wr_q      <= 1'b1;
                                state_q   <= StDone;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StRfetch: begin
                        // Read data arrives the cycle after the strobe has dropped.
                        if (!rd_q) begin
                            shift_out_q <= in_reg_rdata;
                            last_q      <= 1'b0;
                            state_q     <= StRdata;
                        end
                    end
                    StRdata: begin
                        if (clk_fall) begin
                            if (last_q) begin
                                oe_q    <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= StDone;
                            end else begin
                                oe_q        <= 1'b1;
                                dout_q      <= shift_out_q[DataW-1];
                                shift_out_q <= {shift_out_q[DataW-2:0], 1'b0};
                            end
                        end else if (clk_rise) begin
                            if (bit_cnt_q == DataLast) begin
                                bit_cnt_q <= '0;
                                last_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (!cs_lvl) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            oe_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StWaitIdle;
                        busy_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_tw_data    = oe_q ? dout_q : 1'bz;
    assign out_reg_addr  = addr_q;
    assign out_reg_wdata = wdata_q;
    assign out_reg_wr    = wr_q;
    assign out_reg_rd    = rd_q;
    assign out_busy      = busy_q;
    assign out_frame_err = err_q;

endmodule

// File: tb/tb_pcl_3w_slave.sv
// Directed bench for pcl_3w_slave: a bus master model, a small register file and pulse counters.
module tb_pcl_3w_slave;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       tw_clk;
    logic       tw_cs;
    logic       m_oe;
    logic       m_dout;
    wire        tw_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_wr;
    logic       reg_rd;
    logic       busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    logic [7:0] mem [128];

    assign tw_data = m_oe ? m_dout : 1'bz;
    pullup (tw_data);

    pcl_3w_slave dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_tw_clock   (tw_clk),
        .in_tw_cs      (tw_cs),
        .io_tw_data    (tw_data),
        .out_reg_addr  (reg_addr),
        .out_reg_wdata (reg_wdata),
        .out_reg_wr    (reg_wr),
        .out_reg_rd    (reg_rd),
        .in_reg_rdata  (reg_rdata),
        .out_busy      (busy),
        .out_frame_err (frame_err)
    );

    initial forever #5 in_clk = ~in_clk;

    // Register file: read data one cycle after the strobe; counts every strobe cycle.
    always @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[7'h12] <= 8'h3C;
            reg_rdata  <= 8'h00;
        end else begin
            if (reg_rd) reg_rdata <= mem[reg_addr];
            if (reg_wr) mem[reg_addr] <= reg_wdata;
        end
        if (reg_wr) wr_cnt <= wr_cnt + 1;
        if (reg_rd) rd_cnt <= rd_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus clock: fall (master updates data), then rise; sample at the end of the high phase.
    task automatic tw_cycle(input int half, input logic bit_out, input logic drive,
                            output logic sampled);
        tw_clk = 1'b0;
        m_dout = bit_out;
        m_oe   = drive;
        cyc(half);
        tw_clk = 1'b1;
        cyc(half);
        sampled = tw_data;
    endtask

    task automatic frame(input int half, input logic [7:0] cmd, input logic [7:0] wdat,
                         input int nclk, output logic [7:0] rdat, output logic bus_end);
        logic s;
        rdat  = 8'h00;
        tw_cs = 1'b1;
        cyc(half);
        for (int i = 0; i < nclk; i++) begin
            if (i < 8) begin
                tw_cycle(half, cmd[7-i], 1'b1, s);
            end else if (i < 16 && !cmd[7]) begin
                tw_cycle(half, wdat[15-i], 1'b1, s);
            end else begin
                tw_cycle(half, 1'b0, 1'b0, s);
                if (i < 16) rdat[15-i] = s;
            end
        end
        tw_clk = 1'b0;
        m_oe   = 1'b0;
        cyc(half);
        bus_end = tw_data;
        tw_cs   = 1'b0;
    endtask

    initial begin
        logic [7:0] rdat;
        logic       bus_end;
        logic       s;
        int         w0, r0, e0, k;

        in_rst = 1'b1;
        tw_clk = 1'b0;
        tw_cs  = 1'b0;
        m_oe   = 1'b0;
        m_dout = 1'b0;
        cyc(5);
        check("rst_wr", reg_wr, 0);
        check("rst_rd", reg_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_err", frame_err, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_bus_z", tw_data, 1);
        in_rst = 1'b0;
        cyc(10);

        // Write 0x05 <- 0xA5
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        frame(5, 8'h05, 8'hA5, 16, rdat, bus_end);
        cyc(10);
        check("wr1_count", wr_cnt - w0, 1);
        check("wr1_nord", rd_cnt - r0, 0);
        check("wr1_noerr", err_cnt - e0, 0);
        check("wr1_addr", reg_addr, 7'h05);
        check("wr1_wdata", reg_wdata, 8'hA5);
        check("wr1_bus_z", bus_end, 1);
        check("wr1_idle", busy, 0);

        // Read 0x12 -> 0x3C
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        frame(5, 8'h92, 8'h00, 16, rdat, bus_end);
        cyc(10);
        check("rd1_count", rd_cnt - r0, 1);
        check("rd1_nowr", wr_cnt - w0, 0);
        check("rd1_addr", reg_addr, 7'h12);
        check("rd1_data", rdat, 8'h3C);
        check("rd1_bus_z", bus_end, 1);
        check("rd1_noerr", err_cnt - e0, 0);

        // Abort after 4 command bits
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        tw_cs = 1'b1;
        cyc(5);
        for (int i = 0; i < 4; i++) tw_cycle(5, (i == 0), 1'b1, s);
        check("abort_busy_pre", busy, 1);
        tw_cs = 1'b0;
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            k = i;
            if (!busy) break;
        end
        check("abort_busy_lat", (k <= 4), 1);
        tw_clk = 1'b0;
        m_oe   = 1'b0;
        cyc(10);
        check("abort_err", err_cnt - e0, 1);
        check("abort_nowr", wr_cnt - w0, 0);
        check("abort_nord", rd_cnt - r0, 0);
        check("abort_addr_hold", reg_addr, 7'h12);

        // 20 bus clocks in one write frame
        w0 = wr_cnt; e0 = err_cnt;
        frame(5, 8'h33, 8'h5A, 20, rdat, bus_end);
        cyc(10);
        check("xtra_count", wr_cnt - w0, 1);
        check("xtra_noerr", err_cnt - e0, 0);
        check("xtra_addr", reg_addr, 7'h33);
        check("xtra_wdata", reg_wdata, 8'h5A);
        check("xtra_bus_z", bus_end, 1);

        // Reset in the middle of a read of 0x21 (data 0x00, so a driven bit reads 0)
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        tw_cs = 1'b1;
        cyc(5);
        for (int i = 0; i < 8; i++) tw_cycle(5, (i == 0 || i == 7 || i == 2), 1'b1, s);
        for (int i = 0; i < 3; i++) tw_cycle(5, 1'b0, 1'b0, s);
        tw_clk = 1'b0;
        m_oe   = 1'b0;
        cyc(5);
        check("rstmid_driving", tw_data, 0);
        in_rst = 1'b1;
        cyc(1);
        check("rstmid_bus_z", tw_data, 1);
        in_rst = 1'b0;
        check("rstmid_busy", busy, 0);
        // Keep clocking a full write with cs still high: must be ignored
        for (int i = 0; i < 16; i++) tw_cycle(5, (i == 5 || i == 7 || i == 11), 1'b1, s);
        tw_clk = 1'b0;
        m_oe   = 1'b0;
        cyc(5);
        check("rstmid_ignored_wr", wr_cnt - w0, 0);
        check("rstmid_rd_once", rd_cnt - r0, 1);
        check("rstmid_noerr", err_cnt - e0, 0);
        check("rstmid_busy_held", busy, 0);
        tw_cs = 1'b0;
        cyc(10);
        frame(5, 8'h05, 8'h66, 16, rdat, bus_end);
        cyc(10);
        check("rstmid_next_wr", wr_cnt - w0, 1);
        check("rstmid_next_wdata", reg_wdata, 8'h66);

        // Back-to-back at in_clk/8 with a one-cycle cs gap
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        frame(4, 8'h7F, 8'hFF, 16, rdat, bus_end);
        cyc(1);
        frame(4, 8'hFF, 8'h00, 16, rdat, bus_end);
        cyc(10);
        check("b2b_wr", wr_cnt - w0, 1);
        check("b2b_rd", rd_cnt - r0, 1);
        check("b2b_noerr", err_cnt - e0, 0);
        check("b2b_addr", reg_addr, 7'h7F);
        check("b2b_wdata", reg_wdata, 8'hFF);
        check("b2b_rdata", rdat, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
